// File: rtl/fifo_pkg.sv
// Shared FIFO types, default geometry and pointer-width helper.
package fifo_pkg;

  // Read-side behaviour of the FIFO
  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Default geometry, also used by the UVM transaction and scoreboard model
  localparam int unsigned FIFO_DEFAULT_DW    = 8;
  localparam int unsigned FIFO_DEFAULT_DEPTH = 8;
  localparam int unsigned FIFO_DEFAULT_AFM   = 1;
  localparam int unsigned FIFO_DEFAULT_AEM   = 1;

  // Pointer width: index bits plus one wrap bit
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x DATA_WIDTH register array.
// Ports: clk_i clock; we_i/waddr_i/wdata_i synchronous write port;
//        raddr_i/rdata_o asynchronous read port. Contents are not reset.
module fifo_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port returns pre-edge contents, so a same-entry write is not seen
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, synchronous flush,
// sticky overflow/underflow flags and registered or fall-through read.
// Ports: clock, reset (async active-low); data_in/wn write; rn read/pop;
//        flush clears contents; clr_err clears sticky flags;
//        data_out read data; full/empty/almost_full/almost_empty status;
//        count occupancy 0..DEPTH; overflow/underflow sticky errors.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DEFAULT_DW,
  parameter int unsigned DEPTH      = FIFO_DEFAULT_DEPTH,
  parameter int unsigned AF_MARGIN  = FIFO_DEFAULT_AFM,
  parameter int unsigned AE_MARGIN  = FIFO_DEFAULT_AEM,
  parameter int unsigned FWFT       = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       wn,
  input  logic                       rn,
  input  logic                       flush,
  input  logic                       clr_err,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = PW;
  localparam fifo_mode_e  MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  localparam logic [CW-1:0] AF_LVL = CW'(DEPTH - AF_MARGIN);
  localparam logic [CW-1:0] AE_LVL = CW'(AE_MARGIN);
  localparam logic          AF_RST = (DEPTH <= AF_MARGIN);

  // Elaboration-time parameter sanity
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 2");
  end
  if ((AF_MARGIN >= DEPTH) || (AE_MARGIN >= DEPTH)) begin : g_bad_margin
    $error("sync_fifo_param: AF_MARGIN and AE_MARGIN must be < DEPTH");
  end

  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;

  logic                  rd_ok;
  logic                  wr_ok;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] rdata;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk_i   (clock),
    .we_i    (mem_we),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (data_in),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (rdata)
  );

  // Acceptance: a read on a full FIFO frees the slot for a same-cycle write
  always_comb begin
    rd_ok  = rn && !empty_q;
    wr_ok  = wn && (!full_q || rd_ok);
    mem_we = wr_ok && !flush;
  end

  // Next-state for pointers, count, status flags, errors and output register
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    dout_d  = dout_q;

    if (clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end

    if (flush) begin
      // Flush wins over the same-cycle requests and raises no errors
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_ok) begin
        wptr_d = wptr_q + PW'(1);
      end
      if (rd_ok) begin
        rptr_d = rptr_q + PW'(1);
        if (MODE == FIFO_STD) begin
          dout_d = rdata;
        end
      end
      count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
      // Set has priority over a same-cycle clr_err
      if (wn && !wr_ok) begin
        ovf_d = 1'b1;
      end
      if (rn && !rd_ok) begin
        unf_d = 1'b1;
      end
    end

    empty_d = (wptr_d == rptr_d);
    full_d  = (wptr_d[AW-1:0] == rptr_d[AW-1:0]) && (wptr_d[AW] != rptr_d[AW]);
    af_d    = (count_d >= AF_LVL);
    ae_d    = (count_d <= AE_LVL);
  end

  // State registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= AF_RST;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      dout_q  <= dout_d;
    end
  end

  // Fall-through shows the head word straight from storage, zero when empty
  always_comb begin
    if (MODE == FIFO_FWFT) begin
      data_out = empty_q ? '0 : rdata;
    end else begin
      data_out = dout_q;
    end
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a registered-read and a fall-through instance
// share one stimulus stream and are checked every cycle against a queue model.
module tb_sync_fifo_param;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          wn = 1'b0, rn = 1'b0, flush = 1'b0, clr_err = 1'b0;

  logic [DW-1:0] d0_dout, d1_dout;
  logic          d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_unf;
  logic          d1_full, d1_empty, d1_af, d1_ae, d1_ovf, d1_unf;
  logic [3:0]    d0_count, d1_count;

  always #5 clock = ~clock;

  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_MARGIN(1), .AE_MARGIN(1), .FWFT(0)) u_std (
    .clock(clock), .reset(reset), .data_in(data_in), .wn(wn), .rn(rn),
    .flush(flush), .clr_err(clr_err), .data_out(d0_dout), .full(d0_full),
    .empty(d0_empty), .almost_full(d0_af), .almost_empty(d0_ae),
    .count(d0_count), .overflow(d0_ovf), .underflow(d0_unf));

  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_MARGIN(1), .AE_MARGIN(1), .FWFT(1)) u_fwft (
    .clock(clock), .reset(reset), .data_in(data_in), .wn(wn), .rn(rn),
    .flush(flush), .clr_err(clr_err), .data_out(d1_dout), .full(d1_full),
    .empty(d1_empty), .almost_full(d1_af), .almost_empty(d1_ae),
    .count(d1_count), .overflow(d1_ovf), .underflow(d1_unf));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model: contents as a queue, plus error flags and the
  // registered-read output word
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dstd;
  logic          m_ovf, m_unf;
  logic          m_rd, m_wr;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_dstd = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else if (flush) begin
      q.delete();
      if (clr_err) begin m_ovf = 1'b0; m_unf = 1'b0; end
    end else begin
      m_rd = rn && (q.size() > 0);
      m_wr = wn && ((q.size() < DEPTH) || m_rd);
      if (m_rd) begin
        m_dstd = q[0];
        void'(q.pop_front());
      end
      if (m_wr) q.push_back(data_in);
      m_ovf = (wn && !m_wr) ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
      m_unf = (rn && !m_rd) ? 1'b1 : (clr_err ? 1'b0 : m_unf);
    end
  end

  // Every-cycle comparison of both instances against the model
  int sz;
  logic [DW-1:0] exp_fw;
  always @(negedge clock) begin
    sz = q.size();
    exp_fw = (sz > 0) ? q[0] : '0;
    chk("std.count", 32'(d0_count), 32'(sz));
    chk("std.full",  32'(d0_full),  32'(sz == DEPTH));
    chk("std.empty", 32'(d0_empty), 32'(sz == 0));
    chk("std.af",    32'(d0_af),    32'(sz >= DEPTH - 1));
    chk("std.ae",    32'(d0_ae),    32'(sz <= 1));
    chk("std.ovf",   32'(d0_ovf),   32'(m_ovf));
    chk("std.unf",   32'(d0_unf),   32'(m_unf));
    chk("std.dout",  32'(d0_dout),  32'(m_dstd));
    chk("fw.count",  32'(d1_count), 32'(sz));
    chk("fw.full",   32'(d1_full),  32'(sz == DEPTH));
    chk("fw.empty",  32'(d1_empty), 32'(sz == 0));
    chk("fw.af",     32'(d1_af),    32'(sz >= DEPTH - 1));
    chk("fw.ae",     32'(d1_ae),    32'(sz <= 1));
    chk("fw.ovf",    32'(d1_ovf),   32'(m_ovf));
    chk("fw.unf",    32'(d1_unf),   32'(m_unf));
    chk("fw.dout",   32'(d1_dout),  32'(exp_fw));
  end

  // One clock of stimulus; returns just after the following falling edge
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d,
                      input logic f, input logic c);
    wn = w; rn = r; data_in = d; flush = f; clr_err = c;
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    @(negedge clock); #1;
    chk("rst.count", 32'(d0_count), 32'd0);
    chk("rst.empty", 32'(d0_empty), 32'd1);
    chk("rst.ae",    32'(d0_ae),    32'd1);
    chk("rst.af",    32'(d0_af),    32'd0);
    chk("rst.dout0", 32'(d0_dout),  32'h00);
    chk("rst.dout1", 32'(d1_dout),  32'h00);

    // Fill, overflow, drain in order
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, DW'(i), 0, 0);
      if (i == 6) chk("t1.af6", 32'(d0_af), 32'd0);
      if (i == 7) chk("t1.af7", 32'(d0_af), 32'd1);
    end
    chk("t1.full",  32'(d0_full),  32'd1);
    chk("t1.count", 32'(d0_count), 32'd8);
    step(1, 0, 8'hFF, 0, 0);
    chk("t1.ovf",   32'(d0_ovf),   32'd1);
    chk("t1.cnt9",  32'(d0_count), 32'd8);
    chk("t1.fwhd",  32'(d1_dout),  32'h01);
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 8'h00, 0, 0);
      chk("t1.rd", 32'(d0_dout), 32'(i));
    end
    chk("t1.empty", 32'(d0_empty), 32'd1);

    // Underflow and sticky clear
    step(0, 0, 8'h00, 0, 1);
    chk("t2.ovfclr", 32'(d0_ovf), 32'd0);
    step(0, 1, 8'h00, 0, 0);
    chk("t2.unf",   32'(d0_unf),  32'd1);
    chk("t2.hold",  32'(d0_dout), 32'h08);
    step(0, 0, 8'h00, 0, 1);
    chk("t2.clr",   32'(d0_unf),  32'd0);
    step(0, 1, 8'h00, 0, 1);
    chk("t2.setwin", 32'(d1_unf), 32'd1);
    step(0, 0, 8'h00, 0, 1);

    // Full with simultaneous read and write
    for (int i = 0; i < 8; i++) step(1, 0, 8'h10 + DW'(i), 0, 0);
    step(1, 1, 8'hAA, 0, 0);
    chk("t3.dout",  32'(d0_dout),  32'h10);
    chk("t3.count", 32'(d0_count), 32'd8);
    chk("t3.ovf",   32'(d0_ovf),   32'd0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 8'h00, 0, 0);
      chk("t3.rd", 32'(d0_dout), (i < 7) ? 32'h11 + 32'(i) : 32'hAA);
    end

    // Fall-through visibility
    step(1, 0, 8'h5A, 0, 0);
    chk("t4.empty", 32'(d1_empty), 32'd0);
    chk("t4.dout",  32'(d1_dout),  32'h5A);
    step(0, 1, 8'h00, 0, 0);
    chk("t4.empty2", 32'(d1_empty), 32'd1);
    chk("t4.dout2",  32'(d1_dout),  32'h00);

    // Flush with concurrent requests
    for (int i = 0; i < 5; i++) step(1, 0, 8'h40 + DW'(i), 0, 0);
    step(1, 1, 8'h77, 1, 0);
    chk("t5.count", 32'(d0_count), 32'd0);
    chk("t5.empty", 32'(d1_empty), 32'd1);
    chk("t5.errs",  32'({d0_ovf, d0_unf}), 32'd0);
    chk("t5.dstd",  32'(d0_dout), 32'h5A);
    chk("t5.dfw",   32'(d1_dout), 32'h00);
    step(1, 0, 8'h33, 0, 0);
    chk("t5.fw33",  32'(d1_dout), 32'h33);
    step(0, 1, 8'h00, 0, 0);
    chk("t5.rd33",  32'(d0_dout), 32'h33);

    // Asynchronous reset between edges
    for (int i = 0; i < 3; i++) step(1, 0, 8'h60 + DW'(i), 0, 0);
    #2 reset = 1'b0;
    #1;
    chk("t6.count", 32'(d0_count), 32'd0);
    chk("t6.empty", 32'(d0_empty), 32'd1);
    chk("t6.dstd",  32'(d0_dout),  32'h00);
    chk("t6.dfw",   32'(d1_dout),  32'h00);
    @(negedge clock); #1;
    reset = 1'b1;
    @(negedge clock); #1;

    // Mixed traffic: write-heavy, balanced, read-heavy
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 20; i++) begin
        logic w, rd;
        case (r)
          0:       begin w = (i % 4) != 3; rd = (i % 3) == 0; end
          1:       begin w = (i % 3) != 0; rd = (i % 3) != 1; end
          default: begin w = (i % 4) == 0; rd = 1'b1;         end
        endcase
        step(w, rd, DW'(r * 64 + i * 5 + 1), 0, (i == 10));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO. It is the next-generation replacement for the fixed 8x8 FIFO used by the datapath and UVM benches. Width, depth, almost-thresholds and read mode (registered or first-word-fall-through) are configurable. It uses all DEPTH entries, and adds an occupancy count, synchronous flush and sticky overflow/underflow error flags.

Parameters:
DATA_WIDTH, 8, bits per word
DEPTH, 8, number of entries; power of two, >= 2
AF_MARGIN, 1, almost_full asserts when count >= DEPTH - AF_MARGIN
AE_MARGIN, 1, almost_empty asserts when count <= AE_MARGIN
FWFT, 0, 0 = registered read (data valid 1 cycle after rn); 1 = first-word-fall-through

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
data_in  in  DATA_WIDTH  write data
wn  in  1  write request
rn  in  1  read request / pop
flush  in  1  synchronous clear of contents
clr_err  in  1  synchronous clear of sticky error flags
data_out  out  DATA_WIDTH  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= DEPTH - AF_MARGIN
almost_empty  out  1  count <= AE_MARGIN
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a write was rejected
underflow  out  1  sticky: a read was rejected

Behaviour:
- Reset (reset=0, asynchronous):
  - wptr, rptr, count, data_out, overflow and underflow go to 0.
  - empty=1, full=0, almost_empty=1; almost_full=0 (unless AF_MARGIN >= DEPTH).
  - Memory contents need not be reset.
- Pointers:
  - log2(DEPTH)+1 bits; the MSB is the wrap bit.
  - Equal pointers means empty; equal index bits with differing wrap bit means full.
  - Pointers wrap naturally modulo 2*DEPTH.
- Read acceptance: rd_ok = rn && !empty.
- Write acceptance: wr_ok = wn && (!full || rd_ok). When full, a simultaneous accepted read frees a slot, so the write is accepted and count is unchanged.
- When empty and wn && rn: the write is accepted, the read is rejected, underflow is set, count becomes 1.
- Count update: count += wr_ok - rd_ok, registered. All flags derive from registered count/pointers; no combinational path from wn/rn to flags.
- Error flags:
  - overflow set on wn && !wr_ok; underflow set on rn && !rd_ok.
  - Both stay set until clr_err=1 or reset.
  - If set and clr_err occur in the same cycle, set wins.
- FWFT=0 (registered read):
  - On rd_ok, data_out <= mem[rptr] at the next edge (1-cycle latency).
  - data_out holds its value otherwise, including on rejected reads.
- FWFT=1 (fall-through):
  - data_out = mem[rptr] combinationally when !empty; data_out = 0 when empty.
  - A word written into an empty FIFO is visible on data_out the cycle after the write edge, together with empty deasserting.
  - rd_ok pops the head; the next word appears after that edge.
- Flush:
  - Takes priority over wn/rn in the same cycle. Pointers and count go to 0, so empty=1.
  - The accompanying wn/rn are ignored and do not set error flags.
  - In FWFT=0, data_out is unchanged; in FWFT=1, data_out becomes 0.
- Read-during-write to the same entry cannot occur except when full with a simultaneous read. In that case the read returns the old data.
- Reset mid-operation: all state clears immediately; the first edge after reset=1 behaves as from empty.

Decomposition:
- Package fifo_pkg:
  - fifo_mode_e {FIFO_STD, FIFO_FWFT}.
  - Function ptr_w(depth) returning $clog2(depth)+1.
  - Default width/depth constants shared with the UVM environment (transaction widths, scoreboard model depth).
- Sub-module fifo_mem: DEPTH x DATA_WIDTH register array.
  - One synchronous write port (we, waddr, wdata).
  - One asynchronous read port (raddr, rdata).
  - sync_fifo_param instantiates it and holds the pointers, counter, flags and output register.
- Elaboration assertion: DEPTH must be a power of two, and AF_MARGIN and AE_MARGIN must be < DEPTH.

Test Plan:
1. DEPTH=8, FWFT=0: write 0x01..0x08 → full=1, count=8, almost_full from count=7. A 9th write of 0xFF → overflow=1, count stays 8. Read 8 times → data_out 0x01..0x08, each one cycle after rn; empty=1.
2. Empty FIFO: rn=1 → underflow=1, data_out unchanged. clr_err pulse → underflow=0. Simultaneous set and clr_err → flag remains 1.
3. Full FIFO (0x10..0x17) with wn=1 (0xAA) and rn=1 in the same cycle → data_out=0x10, count=8, no overflow. 0xAA is read last after wrap-around.
4. FWFT=1: write 0x5A to empty → next cycle empty=0, data_out=0x5A with no rn. rn → empty=1, data_out=0.
5. Write 5 words, then flush=1 with wn=1 and rn=1 → count=0, empty=1, no error flags. The next write of 0x33 reads back 0x33.
6. Fill with 3 words, then drive reset=0 asynchronously between edges → count=0, empty=1, data_out=0 immediately. Normal operation resumes after release; run 3 full wrap cycles of 20 mixed wn/rn against the scoreboard.
